// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory response block.
//   state_t            : MMIO handshake FSM states
//   byte_en_t          : 4-bit store byte-enable (bit i -> byte i, little-endian)
//   MMIO_BASE_DEFAULT  : lowest byte address routed to the MMIO port
package dmem_resp_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  typedef logic [BE_W-1:0] byte_en_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MMIO_WAIT = 2'd1,
    MMIO_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 byte-writable synchronous RAM, one write port and one read port.
//   clk          : clock
//   we / waddr / wdata : byte-enabled write, committed at posedge
//   re / raddr   : read enable and word index
//   rdata        : registered read word, holds when re=0
module dmem_ram
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH = 16384
) (
  input  logic                     clk,
  input  byte_en_t                 we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(BE_W); i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  // Registered read; old data on a same-edge write to the same word
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory response unit: routes loads/stores to on-chip RAM or the MMIO
// port, returns load data with a fixed 2-cycle RAM latency, and stalls the
// pipeline while an MMIO access is outstanding.
//   clk, rst_n (sync, active-low), clk_en (global advance), flush (kill returns)
//   req_re / req_we / req_addr / req_wdata : load/store request
//   stall                : high while an MMIO access is waiting for ack
//   rdata / rdata_valid  : load return
//   mmio_req / mmio_we / mmio_addr / mmio_wdata, mmio_ack / mmio_rdata : MMIO port
module dmem_resp
  import dmem_resp_pkg::*;
#(
  parameter int unsigned DEPTH     = 16384,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              req_re,
  input  byte_en_t          req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              mmio_req,
  output byte_en_t          mmio_we,
  output logic [31:0]       mmio_addr,
  output logic [DATA_W-1:0] mmio_wdata,
  input  logic              mmio_ack,
  input  logic [DATA_W-1:0] mmio_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_t            state;
  logic              supp;      // flush seen while the MMIO load was in flight
  logic              valid_a;   // RAM read issued last cycle (memory_a slot)
  logic [DATA_W-1:0] ram_q;

  logic     is_store;
  logic     is_mmio;
  logic     accept;
  logic     ram_re;
  byte_en_t ram_we;

  // Requests are only taken in IDLE; MMIO_DONE still sees the held request
  assign is_store = |req_we;
  assign is_mmio  = (req_addr >= MMIO_BASE);
  assign accept   = clk_en && rst_n && (state == IDLE) && (req_re || is_store);
  assign ram_re   = accept && !is_mmio && !is_store;
  assign ram_we   = (accept && !is_mmio) ? req_we : byte_en_t'(0);

  assign stall = (state == MMIO_WAIT);

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (req_addr[2 +: AW]),
    .wdata (req_wdata),
    .re    (ram_re),
    .raddr (req_addr[2 +: AW]),
    .rdata (ram_q)
  );

  // Return pipeline and MMIO handshake FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      supp        <= 1'b0;
      valid_a     <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      mmio_req    <= 1'b0;
      mmio_we     <= '0;
      mmio_addr   <= '0;
      mmio_wdata  <= '0;
    end else if (clk_en) begin
      valid_a     <= ram_re && !flush;
      rdata_valid <= valid_a && !flush;
      if (valid_a) rdata <= ram_q;

      case (state)
        IDLE: begin
          if (accept && is_mmio) begin
            state      <= MMIO_WAIT;
            mmio_req   <= 1'b1;
            mmio_we    <= req_we;
            mmio_addr  <= {req_addr[31:2], 2'b00};
            mmio_wdata <= req_wdata;
            supp       <= flush;
          end
        end
        MMIO_WAIT: begin
          if (flush) supp <= 1'b1;
          if (mmio_ack) begin
            mmio_req <= 1'b0;
            supp     <= 1'b0;
            if (mmio_we != byte_en_t'(0)) begin
              state <= IDLE;
            end else begin
              state       <= MMIO_DONE;
              rdata       <= mmio_rdata;
              rdata_valid <= !(supp || flush);
            end
          end
        end
        MMIO_DONE: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: stimulus pushes expected load returns
// (data + cycle) into a queue; a negedge monitor pops on every rdata_valid.
module tb_dmem_resp;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic        flush;
  logic        req_re;
  logic [3:0]  req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        mmio_req;
  logic [3:0]  mmio_we;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_ack;
  logic [31:0] mmio_rdata;

  int   compared;
  int   mismatched;
  int   cyc;
  exp_t exp_q[$];

  dmem_resp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk_en      (clk_en),
    .flush       (flush),
    .req_re      (req_re),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .mmio_req    (mmio_req),
    .mmio_we     (mmio_we),
    .mmio_addr   (mmio_addr),
    .mmio_wdata  (mmio_wdata),
    .mmio_ack    (mmio_ack),
    .mmio_rdata  (mmio_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rdata_valid must match the oldest expected return
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rdata_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_return: got rdata=%h at cycle %0d, expected no return", rdata, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", rdata, e.data);
        chk("return_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] exp, input bit push);
    req_re   = 1'b1;
    req_we   = 4'h0;
    req_addr = addr;
    if (push) exp_q.push_back('{exp, cyc + 2});
    step();
    req_re = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] we,
                       input logic [31:0] data, input logic re);
    req_re    = re;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    step();
    req_re = 1'b0;
    req_we = 4'h0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    clk_en     = 1'b1;
    flush      = 1'b0;
    req_re     = 1'b0;
    req_we     = 4'h0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mmio_ack   = 1'b0;
    mmio_rdata = 32'h0;
    repeat (2) step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_rdata_valid", 32'(rdata_valid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mmio_req", 32'(mmio_req), 32'h0);
    chk("rst_mmio_addr", mmio_addr, 32'h0);

    // Store then load next cycle
    store(32'h100, 4'hF, 32'hDEADBEEF, 1'b0);
    load(32'h100, 32'hDEADBEEF, 1'b1);

    // Partial byte merge
    store(32'h200, 4'hF, 32'h11223344, 1'b0);
    store(32'h200, 4'b0010, 32'h0000AA00, 1'b0);
    load(32'h200, 32'h1122AA44, 1'b1);

    // Back-to-back loads
    store(32'h0, 4'hF, 32'hA0A0A0A0, 1'b0);
    store(32'h4, 4'hF, 32'hA4A4A4A4, 1'b0);
    store(32'h8, 4'hF, 32'hA8A8A8A8, 1'b0);
    load(32'h0, 32'hA0A0A0A0, 1'b1);
    load(32'h4, 32'hA4A4A4A4, 1'b1);
    load(32'h8, 32'hA8A8A8A8, 1'b1);

    // Upper address bits alias onto the same word
    load(32'h0001_0100, 32'hDEADBEEF, 1'b1);

    // re+we is a store only, no return
    store(32'h300, 4'hF, 32'h55667788, 1'b1);
    load(32'h300, 32'h55667788, 1'b1);
    repeat (3) step();

    // MMIO load, ack in third wait cycle
    req_re   = 1'b1;
    req_addr = 32'hFFFF_0010;
    step();
    req_re = 1'b0;
    chk("mmio_req_rise", 32'(mmio_req), 32'h1);
    chk("mmio_addr", mmio_addr, 32'hFFFF_0010);
    chk("mmio_we_load", 32'(mmio_we), 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("mmio_wait_stall", 32'(stall), 32'h1);
      if (i == 2) begin
        mmio_ack   = 1'b1;
        mmio_rdata = 32'hCAFE0001;
        exp_q.push_back('{32'hCAFE0001, cyc + 1});
      end
      step();
    end
    mmio_ack = 1'b0;
    chk("mmio_done_stall", 32'(stall), 32'h0);
    chk("mmio_done_req", 32'(mmio_req), 32'h0);
    step();

    // MMIO store acked in the first wait cycle, no return
    store(32'hFFFF_0020, 4'hF, 32'h12345678, 1'b0);
    chk("mmio_st_we", 32'(mmio_we), 32'hF);
    chk("mmio_st_wdata", mmio_wdata, 32'h12345678);
    chk("mmio_st_req", 32'(mmio_req), 32'h1);
    mmio_ack = 1'b1;
    step();
    mmio_ack = 1'b0;
    chk("mmio_st_stall", 32'(stall), 32'h0);
    chk("mmio_st_req_fall", 32'(mmio_req), 32'h0);
    step();

    // Minimum-latency MMIO load
    req_re   = 1'b1;
    req_addr = 32'hFFFF_0004;
    step();
    req_re     = 1'b0;
    mmio_ack   = 1'b1;
    mmio_rdata = 32'h0BADF00D;
    exp_q.push_back('{32'h0BADF00D, cyc + 1});
    step();
    mmio_ack = 1'b0;
    repeat (2) step();

    // Flush kills RAM returns but not earlier stores
    store(32'h40, 4'hF, 32'h40404040, 1'b0);
    store(32'h48, 4'hF, 32'h48484848, 1'b0);
    load(32'h40, 32'h0, 1'b0);
    flush = 1'b1;
    load(32'h44, 32'h0, 1'b0);
    flush = 1'b0;
    load(32'h48, 32'h48484848, 1'b1);
    load(32'h40, 32'h40404040, 1'b1);
    repeat (3) step();

    // Flush during MMIO wait: access completes, return suppressed
    req_re   = 1'b1;
    req_addr = 32'hFFFF_0030;
    step();
    req_re = 1'b0;
    flush  = 1'b1;
    chk("flush_mmio_req", 32'(mmio_req), 32'h1);
    step();
    flush = 1'b0;
    chk("flush_mmio_req_held", 32'(mmio_req), 32'h1);
    chk("flush_mmio_stall", 32'(stall), 32'h1);
    mmio_ack   = 1'b1;
    mmio_rdata = 32'hBAD0BAD0;
    step();
    mmio_ack = 1'b0;
    chk("flush_mmio_done_stall", 32'(stall), 32'h0);
    repeat (3) step();

    // clk_en=0 holds FSM and ignores ack
    req_re   = 1'b1;
    req_addr = 32'hFFFF_0040;
    step();
    req_re     = 1'b0;
    clk_en     = 1'b0;
    mmio_ack   = 1'b1;
    mmio_rdata = 32'hFFFFFFFF;
    step();
    chk("clken_stall_a", 32'(stall), 32'h1);
    step();
    chk("clken_stall_b", 32'(stall), 32'h1);
    clk_en   = 1'b1;
    mmio_ack = 1'b0;
    step();
    chk("clken_stall_c", 32'(stall), 32'h1);
    mmio_ack   = 1'b1;
    mmio_rdata = 32'h13572468;
    exp_q.push_back('{32'h13572468, cyc + 1});
    step();
    mmio_ack = 1'b0;
    repeat (2) step();

    // clk_en=0 stretches the RAM return; requests ignored meanwhile
    load(32'h100, 32'hDEADBEEF, 1'b0);
    exp_q.push_back('{32'hDEADBEEF, cyc + 3});
    clk_en   = 1'b0;
    req_re   = 1'b1;
    req_addr = 32'h200;
    repeat (2) step();
    clk_en = 1'b1;
    req_re = 1'b0;
    repeat (4) step();

    // Reset during MMIO wait abandons the access
    req_re   = 1'b1;
    req_addr = 32'hFFFF_0050;
    step();
    req_re = 1'b0;
    chk("rst_wait_stall", 32'(stall), 32'h1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_wait_req", 32'(mmio_req), 32'h0);
    chk("rst_wait_stall_low", 32'(stall), 32'h0);
    chk("rst_wait_valid", 32'(rdata_valid), 32'h0);

    // Reset discards an outstanding RAM return; RAM contents survive
    load(32'h100, 32'h0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("rst_ram_valid", 32'(rdata_valid), 32'h0);
    load(32'h100, 32'hDEADBEEF, 1'b1);
    repeat (4) step();

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL missing_returns: got %0d outstanding expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 Parameter DEPTH, default 16384, on-chip RAM size in 32-bit words (power of two).
REQ-002 Parameter MMIO_BASE, default 32'hFFFF_0000, lowest byte address routed to the MMIO port.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 clk_en  input  1  global advance enable; when 0 all state holds.
REQ-006 flush  input  1  writeback redirect (exception/rfe); kills in-flight read returns.
REQ-007 req_re  input  1  load request this cycle.
REQ-008 req_we  input  4  store byte enables; bit i writes byte i, little-endian.
REQ-009 req_addr  input  32  physical byte address; bits [1:0] ignored.
REQ-010 req_wdata  input  32  store data, already lane-aligned.
REQ-011 stall  output  1  pipeline hold while an MMIO access is outstanding.
REQ-012 rdata  output  32  load return word.
REQ-013 rdata_valid  output  1  rdata valid this cycle.
REQ-014 mmio_req / mmio_we[4] / mmio_addr[32] / mmio_wdata[32]  output  MMIO request, held stable while mmio_req=1.
REQ-015 mmio_ack  input  1, mmio_rdata  input  32  MMIO completion and load data.

Function
REQ-016 Accepted request: clk_en=1, stall=0, rst_n=1, and (req_re=1 or req_we!=0); request cycle is T.
REQ-017 req_re=1 with req_we!=0 treated as store only; no read return.
REQ-018 RAM region (req_addr < MMIO_BASE): index = req_addr[2+:log2(DEPTH)], upper bits aliased.
REQ-019 RAM store: enabled bytes written at edge ending T; a load accepted at T+1 to the same word returns the merged value.
REQ-020 RAM load: rdata_valid=1 and rdata=word during cycle T+2, fixed latency 2 (one register per memory_a/memory_b stage).
REQ-021 Back-to-back RAM loads every cycle sustain one return per cycle, in order.
REQ-022 FSM states IDLE, MMIO_WAIT, MMIO_DONE; RAM accesses occur only in IDLE.
REQ-023 IDLE -> MMIO_WAIT on an accepted request with req_addr >= MMIO_BASE; request fields captured at edge ending T.
REQ-024 MMIO_WAIT: mmio_req=1, stall=1; on mmio_ack=1 capture mmio_rdata and go MMIO_DONE (stores go straight to IDLE).
REQ-025 MMIO_DONE (one cycle): stall=0, rdata_valid=1 with captured data unless suppressed; next state IDLE.
REQ-026 mmio_ack in the same cycle mmio_req first rises is legal; minimum MMIO load latency is therefore T+2.
REQ-027 flush=1 clears both RAM return slots at that edge; no rdata_valid from loads accepted at or before that cycle.
REQ-028 flush during MMIO_WAIT does not drop mmio_req; the access completes and its rdata_valid is suppressed.
REQ-029 flush does not undo a store already accepted.
REQ-030 clk_en=0: FSM, return slots, captured MMIO fields hold; mmio_ack ignored.
REQ-031 Outputs are registered except stall, which decodes state==MMIO_WAIT.

Reset
REQ-032 rst_n=0 at posedge: state IDLE, stall=0, rdata_valid=0, rdata=0, mmio_req=0, mmio_we=0, mmio_addr=0, mmio_wdata=0, flush-suppress flag=0; RAM contents not reset.
REQ-033 Reset mid-MMIO_WAIT abandons the access (mmio_req low next cycle); outstanding RAM returns discarded.

Structure
REQ-034 Shared package holds the FSM state enum, MMIO_BASE default and the 4-bit byte-enable type.
REQ-035 One sub-module, dmem_ram: DEPTH x 32 byte-writable synchronous RAM, one read port and one write port.

Verification
REQ-036 Store 32'hDEADBEEF, we=4'hF, addr 0x100 at T; load 0x100 at T+1 -> rdata=32'hDEADBEEF, valid at T+3.
REQ-037 Word 0x200=32'h11223344; store we=4'b0010 wdata 32'h0000AA00; load -> 32'h1122AA44.
REQ-038 Loads 0x0,0x4,0x8 on consecutive cycles -> three consecutive valid returns, same order.
REQ-039 Load MMIO 0xFFFF_0010, ack after 3 wait cycles with 32'hCAFE0001 -> stall high 3 cycles, then rdata=32'hCAFE0001 valid once.
REQ-040 Load 0x40 at T, flush at T+1 -> no rdata_valid at T+2; flush during MMIO_WAIT -> mmio_req held to ack, no rdata_valid.
REQ-041 rst_n low during MMIO_WAIT -> next cycle mmio_req=0, stall=0, rdata_valid=0.
